// File: rtl/vit_tbck_ctrl.sv
// vit_tbck_ctrl: survivor memory and traceback controller; buffers one frame of ACS
// decisions, traces back from the supplied end state, and streams decoded bits in time order.
module vit_tbck_ctrl #(
    parameter int M         = 2,
    parameter int FRAME_MAX = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [(1<<M)-1:0] in_dec,
    input  logic              in_last,
    input  logic [M-1:0]      start_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic              busy,
    output logic              ovf
);
    localparam int NSTATE = 1 << M;
    localparam int IW     = $clog2(FRAME_MAX);
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, TRACE = 2'd2, OUTPUT = 2'd3;
    logic [1:0]           state;
    logic [NSTATE-1:0]    mem [FRAME_MAX];
    logic [FRAME_MAX-1:0] obuf;
    logic [CNT_W-1:0]     wr_cnt, n_sym, tb_idx, rd_idx;
    logic [M-1:0]         tb_state;
    logic                 accept, forced;
    assign in_ready  = (state == IDLE) || (state == WRITE);
    assign busy      = (state == TRACE) || (state == OUTPUT);
    assign out_valid = state == OUTPUT;
    assign accept    = in_valid & in_ready;
    assign forced    = (state == WRITE) && (wr_cnt == CNT_W'(FRAME_MAX - 1));
    assign out_bit   = out_valid & obuf[rd_idx[IW-1:0]];
    assign out_last  = out_valid && (rd_idx == n_sym - 1'b1);
    // Storage carries no reset: contents are always rewritten before they are read.
    always_ff @(posedge clk) begin
        if (accept) mem[state == IDLE ? '0 : wr_cnt[IW-1:0]] <= in_dec;
        if (state == TRACE) obuf[tb_idx[IW-1:0]] <= tb_state[M-1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            n_sym    <= '0;
            tb_idx   <= '0;
            rd_idx   <= '0;
            tb_state <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    wr_cnt <= CNT_W'(1);
                    ovf    <= 1'b0;
                    if (in_last) begin
                        tb_state <= start_state;
                        n_sym    <= CNT_W'(1);
                        tb_idx   <= '0;
                        state    <= TRACE;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: if (accept) begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (in_last || forced) begin
                        tb_state <= start_state;
                        n_sym    <= wr_cnt + 1'b1;
                        tb_idx   <= wr_cnt;
                        ovf      <= ovf | ~in_last;
                        state    <= TRACE;
                    end
                end
                TRACE: begin
                    tb_state <= {tb_state[M-2:0], mem[tb_idx[IW-1:0]][tb_state]};
                    tb_idx   <= tb_idx - 1'b1;
                    if (tb_idx == '0) begin
                        rd_idx <= '0;
                        state  <= OUTPUT;
                    end
                end
                OUTPUT: if (out_ready) begin
                    rd_idx <= rd_idx + 1'b1;
                    if (out_last) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vit_tbck_ctrl.sv
// tb_vit_tbck_ctrl: randomized and directed checks of the traceback controller against
// a frame-level reference that replays the traceback rule over the stored decisions.
module tb_vit_tbck_ctrl;
    localparam int M = 2, NS = 4, FM = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [NS-1:0] in_dec = '0;
    logic [M-1:0] start_state = '0;
    logic in_ready, out_valid, out_bit, out_last, busy, ovf;
    int total = 0, bad = 0;
    logic [NS-1:0] dec [FM];
    logic [FM-1:0] got, exp_bits;
    int got_n, last_pos, hold_bad, inrdy_bad, busy_bad, lat;
    bit to;

    vit_tbck_ctrl #(.M(M), .FRAME_MAX(FM), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
        .in_last(in_last), .start_state(start_state), .out_valid(out_valid),
        .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Bit at time t is the MSB of the survivor state at t; walk the path backwards.
    function automatic logic [FM-1:0] model(input int n, input logic [M-1:0] st);
        logic [M-1:0] s;
        logic [FM-1:0] r;
        s = st;
        r = '0;
        for (int t = n - 1; t >= 0; t--) begin
            r[t] = s[M-1];
            s = {s[M-2:0], dec[t][s]};
        end
        return r;
    endfunction

    task automatic send(input int n, input logic lastflag, input logic [M-1:0] st, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); in_valid = 1'b0; end
            @(negedge clk);
            in_valid = 1'b1;
            in_dec = dec[i];
            in_last = lastflag && (i == n - 1);
            start_state = st;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // mode 0: always ready, 1: fixed 1,0,0,1,0,1,1 pattern, 2: random
    task automatic collect(input int mode, input int max_bits);
        int step;
        bit stalled;
        logic pb, pl, rdy;
        got = '0; got_n = 0; last_pos = -1; hold_bad = 0; inrdy_bad = 0; busy_bad = 0;
        lat = 0; to = 0; step = 0; stalled = 0; pb = 0; pl = 0;
        out_ready = 1'b0;
        while (!out_valid) begin
            if (in_ready !== 1'b0) inrdy_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (lat >= 200) begin to = 1; return; end
            @(negedge clk);
            lat++;
        end
        for (int c = 0; c < 400; c++) begin
            if (out_valid !== 1'b1) begin to = 1; return; end
            if (in_ready !== 1'b0) inrdy_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (stalled && (out_bit !== pb || out_last !== pl)) hold_bad++;
            rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(7'b1101001 >> (step % 7)) : 1'($urandom_range(0, 1));
            step++;
            out_ready = rdy;
            stalled = !rdy;
            pb = out_bit;
            pl = out_last;
            if (rdy) begin
                if (got_n < FM) got[got_n] = out_bit;
                if (out_last === 1'b1 && last_pos < 0) last_pos = got_n;
                got_n++;
                if (out_last === 1'b1 || got_n == max_bits) return;
            end
            @(negedge clk);
        end
        to = 1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total += 6;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (out_bit !== 1'b0) begin bad++; $display("FAIL reset_out_bit got=%b want=0", out_bit); end
        if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    endtask

    task automatic load_basic();
        dec[0] = 4'b0000; dec[1] = 4'b0000; dec[2] = 4'b0100; dec[3] = 4'b0000;
    endtask

    task automatic check_frame(input string name, input int n, input logic exp_ovf, input bit chk_lat);
        exp_bits = model(n, start_state);
        total += 7;
        if (to) begin bad++; $display("FAIL %s_timeout got=1 want=0", name); end
        if (got !== exp_bits) begin bad++; $display("FAIL %s_bits got=%h want=%h", name, got, exp_bits); end
        if (got_n !== n) begin bad++; $display("FAIL %s_count got=%0d want=%0d", name, got_n, n); end
        if (last_pos !== n - 1) begin bad++; $display("FAIL %s_last got=%0d want=%0d", name, last_pos, n - 1); end
        if (chk_lat && lat !== n) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, n); end
        if (inrdy_bad + busy_bad + hold_bad != 0) begin
            bad++; $display("FAIL %s_status inrdy=%0d busy=%0d hold=%0d want=0", name, inrdy_bad, busy_bad, hold_bad);
        end
        if (ovf !== exp_ovf) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, ovf, exp_ovf); end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total += 2;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_idle out_valid=%b busy=%b want=0", name, out_valid, busy);
        end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_after got=%b want=1", name, in_ready); end
    endtask

    task automatic test_basic();
        load_basic();
        send(4, 1'b1, 2'b11, 0);
        collect(0, 99);
        total++;
        if (got[3:0] !== 4'b1101) begin bad++; $display("FAIL basic_seq got=%b want=1101", got[3:0]); end
        check_frame("basic", 4, 1'b0, 1);
    endtask

    task automatic test_backpressure();
        load_basic();
        send(4, 1'b1, 2'b11, 0);
        collect(1, 99);
        check_frame("backpressure", 4, 1'b0, 1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < FM; i++) dec[i] = '0;
        send(FM, 1'b0, 2'b00, 0);
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
        collect(0, 99);
        check_frame("overflow", FM, 1'b1, 1);
    endtask

    task automatic test_single();
        dec[0] = 4'($urandom);
        send(1, 1'b1, 2'b10, 0);
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL single_ovf_clear got=%b want=0", ovf); end
        collect(2, 99);
        total++;
        if (got[0] !== 1'b1) begin bad++; $display("FAIL single_bit got=%b want=1", got[0]); end
        check_frame("single", 1, 1'b0, 1);
    endtask

    task automatic test_blocked();
        for (int i = 0; i < 6; i++) dec[i] = 4'($urandom);
        send(6, 1'b1, 2'($urandom), 0);
        in_valid = 1'b1; in_dec = 4'($urandom); in_last = 1'b1;
        collect(0, 99);
        check_frame("blocked", 6, 1'b0, 1);
        in_last = 1'b0;
        test_basic();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FM; i++) dec[i] = '0;
        send(FM, 1'b0, 2'b00, 0);
        collect(0, 2);
        total += 2;
        if (got_n !== 2 || to) begin bad++; $display("FAIL rmid_pre got=%0d want=2", got_n); end
        if (ovf !== 1'b1) begin bad++; $display("FAIL rmid_ovf_pre got=%b want=1", ovf); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b want=0", ovf); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        test_basic();
    endtask

    task automatic test_random();
        int n;
        logic lf;
        for (int f = 0; f < 25; f++) begin
            n = (f % 5 == 0) ? FM : $urandom_range(1, FM);
            lf = (n == FM) ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < FM; i++) dec[i] = 4'($urandom);
            send(n, lf, 2'($urandom), 1);
            collect(2, 99);
            check_frame("random", n, ~lf, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_single();
        test_blocked();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
